// File: rtl/session_tx_arbiter.sv
// session_tx_arbiter: shares one transport TX port among sessions and steers RX packets back
module session_tx_arbiter #(
  parameter int NUM_SESS   = 4,
  parameter int SID_W      = 3,
  parameter int CTRL_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NUM_SESS-1:0] req_cmd,
  input  logic [16*NUM_SESS-1:0] req_data,
  output logic [NUM_SESS-1:0]   req_busy,
  output logic                  tx_valid,
  output logic [1:0]            tx_cmd,
  output logic [15:0]           tx_data,
  output logic [SID_W-1:0]      tx_sess,
  input  logic                  tx_busy,
  input  logic                  rx_valid,
  input  logic [1:0]            rx_cmd,
  input  logic [15:0]           rx_data,
  input  logic [SID_W-1:0]      rx_sess,
  output logic [2*NUM_SESS-1:0] sess_cmd_in,
  output logic [15:0]           sess_packet_in,
  output logic [7:0]            drop_count
);
  logic [NUM_SESS-1:0] full, full_next, req_ok, ctrl_pend, aud_pend, clear;
  logic [1:0] slot_cmd [2**SID_W];
  logic [15:0] slot_data [2**SID_W];
  logic [SID_W-1:0] ctrl_ptr, aud_ptr, ctrl_pick, aud_pick, sel, sel_next;
  logic ctrl_any, aud_any, pick_aud, load, grant, rx_hit;
  logic [3:0] ctrl_streak;
  logic [2*NUM_SESS-1:0] rx_vec;

  // first set bit of mask at or after ptr, wrapping; MSB flags that one was found
  function automatic logic [SID_W:0] rr_pick(input logic [NUM_SESS-1:0] mask, input logic [SID_W-1:0] ptr);
    logic [SID_W:0] r;
    r = '0;
    for (int k = NUM_SESS - 1; k >= 0; k--)
      if (mask[(int'(ptr) + k) % NUM_SESS]) r = {1'b1, SID_W'((int'(ptr) + k) % NUM_SESS)};
    return r;
  endfunction

  assign {ctrl_any, ctrl_pick} = rr_pick(ctrl_pend, ctrl_ptr);
  assign {aud_any, aud_pick}   = rr_pick(aud_pend, aud_ptr);
  assign pick_aud  = aud_any && (!ctrl_any || ctrl_streak == 4'(CTRL_BURST));
  assign sel       = pick_aud ? aud_pick : ctrl_pick;
  assign sel_next  = (sel == SID_W'(NUM_SESS - 1)) ? '0 : sel + 1'b1;
  assign load      = !tx_valid || !tx_busy;
  assign grant     = load && (ctrl_any || aud_any);
  assign full_next = (full & ~clear) | (req_ok & ~full);
  assign rx_hit    = rx_valid && rx_cmd != 2'b00 && int'(rx_sess) < NUM_SESS;

  // per-session request decode, pending classes, and the slot released by this grant
  always_comb begin
    for (int i = 0; i < NUM_SESS; i++) begin
      req_ok[i]    = ^req_cmd[2*i +: 2];
      ctrl_pend[i] = full[i] && slot_cmd[i] == 2'b01;
      aud_pend[i]  = full[i] && slot_cmd[i] == 2'b10;
      clear[i]     = grant && sel == SID_W'(i);
      rx_vec[2*i +: 2] = (rx_hit && rx_sess == SID_W'(i)) ? rx_cmd : 2'b00;
    end
  end

  // pending slots; busy stays up from capture through the cycle after the slot drains
  always_ff @(posedge clk) begin
    full     <= reset ? '0 : full_next;
    req_busy <= reset ? '0 : (full | full_next);
    for (int i = 0; i < NUM_SESS; i++)
      if (req_ok[i] && !full[i]) begin
        slot_cmd[i]  <= req_cmd[2*i +: 2];
        slot_data[i] <= req_data[16*i +: 16];
      end
  end

  // output word register, reloaded when empty or being accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_cmd   <= 2'b00;
      tx_data  <= '0;
      tx_sess  <= '0;
    end else if (load) begin
      tx_valid <= grant;
      if (grant) begin
        tx_cmd  <= slot_cmd[sel];
        tx_data <= slot_data[sel];
        tx_sess <= sel;
      end
    end
  end

  // round-robin pointers and the control-streak starvation guard
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_ptr    <= '0;
      aud_ptr     <= '0;
      ctrl_streak <= '0;
    end else begin
      if (grant && pick_aud) aud_ptr <= sel_next;
      if (grant && !pick_aud) ctrl_ptr <= sel_next;
      if (!aud_any || (grant && pick_aud)) ctrl_streak <= '0;
      else if (grant && ctrl_streak != 4'(CTRL_BURST)) ctrl_streak <= ctrl_streak + 4'd1;
    end
  end

  // saturating count of cycles in which a request hit an occupied slot
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else if (|(req_ok & full) && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

  // receive steering: one-cycle command pulse to the addressed session, word held
  always_ff @(posedge clk) begin
    if (reset) begin
      sess_cmd_in    <= '0;
      sess_packet_in <= '0;
    end else begin
      sess_cmd_in <= rx_vec;
      if (rx_hit) sess_packet_in <= rx_data;
    end
  end
endmodule

// File: tb/tb_session_tx_arbiter.sv
// tb_session_tx_arbiter: directed scoreboard bench for session_tx_arbiter
module tb_session_tx_arbiter;
  localparam int N = 4;
  typedef struct packed { logic [1:0] cmd; logic [2:0] sess; logic [15:0] data; } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2*N-1:0] req_cmd = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0] req_busy;
  logic tx_valid, tx_busy = 1'b0;
  logic [1:0] tx_cmd;
  logic [15:0] tx_data;
  logic [2:0] tx_sess;
  logic rx_valid = 1'b0;
  logic [1:0] rx_cmd = '0;
  logic [15:0] rx_data = '0;
  logic [2:0] rx_sess = '0;
  logic [2*N-1:0] sess_cmd_in;
  logic [15:0] sess_packet_in;
  logic [7:0] drop_count;

  word_t exp_q[$];
  word_t e;
  int checks = 0, errors = 0;
  logic strict = 1'b1;

  session_tx_arbiter #(.NUM_SESS(N), .SID_W(3), .CTRL_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_cmd(req_cmd), .req_data(req_data), .req_busy(req_busy),
    .tx_valid(tx_valid), .tx_cmd(tx_cmd), .tx_data(tx_data), .tx_sess(tx_sess), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_cmd(rx_cmd), .rx_data(rx_data), .rx_sess(rx_sess),
    .sess_cmd_in(sess_cmd_in), .sess_packet_in(sess_packet_in), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  // every accepted word is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!reset && tx_valid && !tx_busy) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_word", 32'({tx_cmd, tx_sess, tx_data}), 32'(e));
      end else if (strict) chk("tx_unexpected", 32'(tx_valid), 32'd0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [1:0] c, input logic [15:0] d);
    req_cmd[2*s +: 2]   = c;
    req_data[16*s +: 16] = d;
  endtask

  task automatic expect_w(input logic [1:0] c, input int s, input logic [15:0] d);
    exp_q.push_back({c, 3'(s), d});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_cmd = '0;
    tx_busy = 1'b0;
    rx_valid = 1'b0;
    step(2);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    chk("rst_req_busy", 32'(req_busy), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_cmd", 32'(tx_cmd), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_sess", 32'(tx_sess), 0);
    chk("rst_sess_cmd_in", 32'(sess_cmd_in), 0);
    chk("rst_sess_packet_in", 32'(sess_packet_in), 0);
    chk("rst_drop_count", 32'(drop_count), 0);

    send(0, 2'b11, 16'hFFFF);
    step();
    req_cmd = '0;
    chk("inv_busy", 32'(req_busy), 0);
    chk("inv_drop", 32'(drop_count), 0);
    step();
    chk("inv_tx_valid", 32'(tx_valid), 0);

    expect_w(2'b01, 2, 16'h0001);
    send(2, 2'b01, 16'h0001);
    step();
    req_cmd = '0;
    chk("single_busy_c1", 32'(req_busy[2]), 1);
    chk("single_valid_c1", 32'(tx_valid), 0);
    step();
    chk("single_valid_c2", 32'(tx_valid), 1);
    chk("single_cmd_c2", 32'(tx_cmd), 1);
    chk("single_data_c2", 32'(tx_data), 1);
    chk("single_sess_c2", 32'(tx_sess), 2);
    chk("single_busy_c2", 32'(req_busy[2]), 1);
    step();
    chk("single_busy_c3", 32'(req_busy[2]), 0);
    chk("single_valid_c3", 32'(tx_valid), 0);
    chk("single_drained", 32'(exp_q.size()), 0);

    expect_w(2'b01, 3, 16'h0005);
    expect_w(2'b10, 0, 16'hAAAA);
    send(0, 2'b10, 16'hAAAA);
    send(3, 2'b01, 16'h0005);
    step();
    req_cmd = '0;
    drain("prio_drain");

    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        expect_w(2'b10, i, 16'(16'hA000 + 16'h1000 * r + i));
        send(i, 2'b10, 16'(16'hA000 + 16'h1000 * r + i));
      end
      step();
      req_cmd = '0;
      drain("rr_drain");
    end

    do_reset();
    expect_w(2'b01, 0, 16'h0B00);
    expect_w(2'b01, 0, 16'h0B02);
    tx_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(0, 2'b01, 16'(16'h0B00 + k));
      step();
      if (k >= 1) begin
        chk("bp_valid_hold", 32'(tx_valid), 1);
        chk("bp_data_hold", 32'(tx_data), 32'h0B00);
      end
    end
    req_cmd = '0;
    chk("bp_drop_count", 32'(drop_count), 8);
    tx_busy = 1'b0;
    drain("bp_drain");

    tx_busy = 1'b1;
    for (int i = 0; i < N; i++) send(i, 2'b01, 16'(16'h0D00 + i));
    step();
    req_cmd = '0;
    step();
    chk("mid_pre_valid", 32'(tx_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_req_busy", 32'(req_busy), 0);
    chk("mid_tx_valid", 32'(tx_valid), 0);
    chk("mid_drop", 32'(drop_count), 8'd0);
    tx_busy = 1'b0;
    step(5);
    chk("mid_idle", 32'(tx_valid), 0);

    rx_valid = 1'b1; rx_sess = 3'd1; rx_cmd = 2'b10; rx_data = 16'h1234;
    step();
    rx_valid = 1'b0;
    chk("rx1_cmd", 32'(sess_cmd_in), 32'h08);
    chk("rx1_pkt", 32'(sess_packet_in), 32'h1234);
    step();
    chk("rx_idle_cmd", 32'(sess_cmd_in), 0);
    chk("rx_idle_pkt", 32'(sess_packet_in), 32'h1234);
    rx_valid = 1'b1; rx_sess = 3'd7; rx_cmd = 2'b01; rx_data = 16'h5555;
    step();
    rx_valid = 1'b0;
    chk("rx7_cmd", 32'(sess_cmd_in), 0);
    chk("rx7_pkt", 32'(sess_packet_in), 32'h1234);
    expect_w(2'b10, 1, 16'h7777);
    send(1, 2'b10, 16'h7777);
    rx_valid = 1'b1; rx_sess = 3'd3; rx_cmd = 2'b01; rx_data = 16'h4321;
    step();
    rx_valid = 1'b0;
    req_cmd = '0;
    chk("rx3_cmd", 32'(sess_cmd_in), 32'h40);
    chk("rx3_pkt", 32'(sess_packet_in), 32'h4321);
    drain("rx_tx_drain");

    do_reset();
    strict = 1'b0;
    expect_w(2'b01, 0, 16'h0C00);
    expect_w(2'b01, 2, 16'h0C02);
    expect_w(2'b01, 3, 16'h0C03);
    expect_w(2'b01, 0, 16'h0C00);
    expect_w(2'b10, 1, 16'h0A01);
    expect_w(2'b01, 2, 16'h0C02);
    send(0, 2'b01, 16'h0C00);
    send(2, 2'b01, 16'h0C02);
    send(3, 2'b01, 16'h0C03);
    send(1, 2'b10, 16'h0A01);
    step();
    send(1, 2'b00, 16'h0000);
    drain("starve_drain");

    do_reset();
    tx_busy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(1, 2'b10, 16'(k));
      step();
    end
    req_cmd = '0;
    chk("drop_saturate", 32'(drop_count), 255);
    do_reset();
    strict = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
